// File: rtl/prog_fetch_pkg.sv
// ============================================================================
// Module  : prog_fetch_pkg
// Brief   : Shared types and constants for the program store / fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_fetch_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    // ADD A,Im with Im=0 - harmless if the CPU ever runs off the program end
    localparam logic [DATA_W-1:0] NOP_WORD = 8'h00;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        PRIME = 2'd2,
        RUN   = 2'd3
    } state_e;

endpackage : prog_fetch_pkg

`default_nettype wire

// File: rtl/prog_ram.sv
// ============================================================================
// Module  : prog_ram
// Brief   : Single-write-port program array with registered read data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_ram
    import prog_fetch_pkg::*;
#(
    parameter int RAM_DATA_W = DATA_W,
    parameter int RAM_ADDR_W = ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [RAM_ADDR_W-1:0] waddr_i,
    input  logic [RAM_DATA_W-1:0] wdata_i,
    input  logic [RAM_ADDR_W-1:0] raddr_i,
    output logic [RAM_DATA_W-1:0] rdata_o
);

    logic [RAM_DATA_W-1:0] mem_q [2**RAM_ADDR_W];
    logic [RAM_DATA_W-1:0] rdata_q;

    // No reset on the array or read register: contents are defined by CLEAR,
    // and the top level masks the read data until the program is primed.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule : prog_ram

`default_nettype wire

// File: rtl/prog_fetch_unit.sv
// ============================================================================
// Module  : prog_fetch_unit
// Brief   : Clears and loads a 16x8 program, then serves ORDER from the CPU PC.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_fetch_unit
    import prog_fetch_pkg::*;
#(
    parameter logic [DATA_W-1:0] FILL_WORD = NOP_WORD
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_VALID,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              WR_LAST,
    output logic              WR_READY,
    input  logic              RELOAD,
    input  logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] ORDER,
    output logic              CPU_RST,
    output logic              LOADED,
    output logic [ADDR_W:0]   PROG_LEN
);

    localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   C_LEN_ONE = (ADDR_W + 1)'(1);

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_ptr_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W:0]     prog_len_q;
    logic                cpu_rst_q;
    logic                loaded_q;
    logic                show_q;

    logic [ADDR_W-1:0]   clr_ptr_d;
    logic [ADDR_W-1:0]   wr_ptr_d;
    logic [ADDR_W:0]     prog_len_d;
    logic                accept;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    assign WR_READY   = (state_q == LOAD);
    assign accept     = WR_VALID & WR_READY;
    assign clr_ptr_d  = clr_ptr_q + C_PTR_ONE;
    assign wr_ptr_d   = wr_ptr_q + C_PTR_ONE;
    assign prog_len_d = prog_len_q + C_LEN_ONE;

    // CLEAR and LOAD are mutually exclusive states, so one write port suffices
    assign ram_we    = (state_q == CLEAR) | accept;
    assign ram_waddr = (state_q == CLEAR) ? clr_ptr_q : wr_ptr_q;
    assign ram_wdata = (state_q == CLEAR) ? FILL_WORD : WR_DATA;

    prog_ram #(
        .RAM_DATA_W (DATA_W),
        .RAM_ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (PC),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            cpu_rst_q  <= 1'b1;
            loaded_q   <= 1'b0;
            show_q     <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_ptr_q <= clr_ptr_d;
                    if (&clr_ptr_q) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_ptr_q   <= wr_ptr_d;
                        prog_len_q <= prog_len_d;
                        if (WR_LAST || (&wr_ptr_q)) begin
                            state_q <= PRIME;
                        end
                    end
                end
                PRIME: begin
                    state_q   <= RUN;
                    show_q    <= 1'b1;
                    cpu_rst_q <= 1'b0;
                    loaded_q  <= 1'b1;
                end
                RUN: begin
                    if (RELOAD) begin
                        state_q    <= CLEAR;
                        clr_ptr_q  <= '0;
                        wr_ptr_q   <= '0;
                        prog_len_q <= '0;
                        cpu_rst_q  <= 1'b1;
                        loaded_q   <= 1'b0;
                        show_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    // ORDER reads as zero until the edge that leaves PRIME captures mem[PC]
    assign ORDER    = show_q ? ram_rdata : '0;
    assign CPU_RST  = cpu_rst_q;
    assign LOADED   = loaded_q;
    assign PROG_LEN = prog_len_q;

endmodule : prog_fetch_unit

`default_nettype wire

// File: tb/tb_prog_fetch_unit.sv
// ============================================================================
// Module  : tb_prog_fetch_unit
// Brief   : Self-checking bench for prog_fetch_unit against a program model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_fetch_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic       WR_VALID;
    logic [7:0] WR_DATA;
    logic       WR_LAST;
    logic       WR_READY;
    logic       RELOAD;
    logic [3:0] PC;
    logic [7:0] ORDER;
    logic       CPU_RST;
    logic       LOADED;
    logic [4:0] PROG_LEN;

    int checks   = 0;
    int failures = 0;

    // Model: the program is the first exp_len words of w_buf, the rest NOP
    logic [7:0] w_buf   [16];
    logic [7:0] exp_mem [16];

    prog_fetch_unit dut (
        .CLK      (CLK),
        .RST      (RST),
        .WR_VALID (WR_VALID),
        .WR_DATA  (WR_DATA),
        .WR_LAST  (WR_LAST),
        .WR_READY (WR_READY),
        .RELOAD   (RELOAD),
        .PC       (PC),
        .ORDER    (ORDER),
        .CPU_RST  (CPU_RST),
        .LOADED   (LOADED),
        .PROG_LEN (PROG_LEN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WR_VALID = 1'b0;
        WR_DATA  = 8'h00;
        WR_LAST  = 1'b0;
        RELOAD   = 1'b0;
    endtask

    task automatic set_exp(input int n);
        for (int i = 0; i < 16; i++) exp_mem[i] = (i < n) ? w_buf[i] : 8'h00;
    endtask

    // Observes the 16 CLEAR cycles; with noise, hammers ignored inputs
    task automatic wait_clear(input bit noise);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (WR_READY !== 1'b0 || ORDER !== 8'h00 || CPU_RST !== 1'b1) begin
                failures++;
                $display("FAIL clear_cyc%0d: ready=%b order=%h cpu_rst=%b, want 0/00/1", i, WR_READY, ORDER, CPU_RST);
            end
            if (noise) begin
                WR_VALID = 1'b1;
                WR_DATA  = 8'($urandom) | 8'h01;
                WR_LAST  = 1'($urandom);
                RELOAD   = 1'($urandom);
                PC       = 4'($urandom);
            end
            tick();
        end
        idle();
        checks++;
        if (WR_READY !== 1'b1 || LOADED !== 1'b0 || PROG_LEN !== 5'd0 || ORDER !== 8'h00) begin
            failures++;
            $display("FAIL clear_done: ready=%b loaded=%b len=%0d order=%h, want 1/0/0/00", WR_READY, LOADED, PROG_LEN, ORDER);
        end
    endtask

    task automatic load_prog(input int n, input bit last_final, input int gap_pct, input bit noise);
        int pp;
        set_exp(n);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                WR_VALID = 1'b0;
                WR_LAST  = 1'($urandom);
                WR_DATA  = 8'($urandom);
                RELOAD   = noise ? 1'($urandom) : 1'b0;
                PC       = 4'($urandom);
                tick();
                checks++;
                if (WR_READY !== 1'b1 || PROG_LEN !== 5'(i) || ORDER !== 8'h00) begin
                    failures++;
                    $display("FAIL load_gap%0d: ready=%b len=%0d order=%h, want 1/%0d/00", i, WR_READY, PROG_LEN, ORDER, i);
                end
            end
            checks++;
            if (WR_READY !== 1'b1) begin
                failures++;
                $display("FAIL load_ready%0d: ready=%b want 1", i, WR_READY);
            end
            WR_VALID = 1'b1;
            WR_DATA  = w_buf[i];
            WR_LAST  = (i == n - 1) && last_final;
            RELOAD   = noise ? 1'($urandom) : 1'b0;
            tick();
        end
        idle();
        checks++;
        if (WR_READY !== 1'b0 || CPU_RST !== 1'b1 || LOADED !== 1'b0 || PROG_LEN !== 5'(n) || ORDER !== 8'h00) begin
            failures++;
            $display("FAIL prime: ready=%b cpu_rst=%b loaded=%b len=%0d order=%h, want 0/1/0/%0d/00",
                     WR_READY, CPU_RST, LOADED, PROG_LEN, ORDER, n);
        end
        pp = noise ? int'($urandom_range(15)) : 0;
        PC = 4'(pp);
        RELOAD = noise ? 1'($urandom) : 1'b0;
        tick();
        RELOAD = 1'b0;
        checks++;
        if (CPU_RST !== 1'b0 || LOADED !== 1'b1 || ORDER !== exp_mem[pp] || PROG_LEN !== 5'(n)) begin
            failures++;
            $display("FAIL run_entry: cpu_rst=%b loaded=%b order=%h len=%0d, want 0/1/%h/%0d",
                     CPU_RST, LOADED, ORDER, PROG_LEN, exp_mem[pp], n);
        end
    endtask

    task automatic read_pc(input int p);
        PC = 4'(p);
        tick();
        checks++;
        if (ORDER !== exp_mem[p] || LOADED !== 1'b1 || CPU_RST !== 1'b0) begin
            failures++;
            $display("FAIL read_pc%0d: order=%h loaded=%b cpu_rst=%b, want %h/1/0", p, ORDER, LOADED, CPU_RST, exp_mem[p]);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle();
        PC = 4'h0;
        tick();
        tick();
        checks++;
        if (CPU_RST !== 1'b1 || LOADED !== 1'b0 || ORDER !== 8'h00 || PROG_LEN !== 5'd0 || WR_READY !== 1'b0) begin
            failures++;
            $display("FAIL reset: cpu_rst=%b loaded=%b order=%h len=%0d ready=%b, want 1/0/00/0/0",
                     CPU_RST, LOADED, ORDER, PROG_LEN, WR_READY);
        end
        RST = 1'b0;
    endtask

    task automatic reload_run(input bit noise);
        RELOAD = 1'b1;
        tick();
        RELOAD = 1'b0;
        checks++;
        if (CPU_RST !== 1'b1 || LOADED !== 1'b0 || ORDER !== 8'h00 || PROG_LEN !== 5'd0 || WR_READY !== 1'b0) begin
            failures++;
            $display("FAIL reload: cpu_rst=%b loaded=%b order=%h len=%0d ready=%b, want 1/0/00/0/0",
                     CPU_RST, LOADED, ORDER, PROG_LEN, WR_READY);
        end
        wait_clear(noise);
    endtask

    task automatic test_reset();
        do_reset();
        wait_clear(1'b0);
    endtask

    task automatic test_short_load();
        w_buf[0] = 8'h31; w_buf[1] = 8'h52; w_buf[2] = 8'hB4;
        load_prog(3, 1'b1, 0, 1'b0);
        for (int p = 0; p < 4; p++) read_pc(p);
    endtask

    task automatic test_full_load();
        reload_run(1'b0);
        for (int i = 0; i < 16; i++) w_buf[i] = 8'(8'h10 + i);
        load_prog(16, 1'b0, 0, 1'b0);
        read_pc(15);
        read_pc(0);
        for (int p = 1; p < 15; p++) read_pc(p);
    endtask

    task automatic test_backpressure();
        do_reset();
        wait_clear(1'b1);
        WR_VALID = 1'b1; WR_DATA = 8'hA1; WR_LAST = 1'b0;
        tick();
        WR_VALID = 1'b0; WR_DATA = 8'hEE; WR_LAST = 1'b1;
        tick();
        checks++;
        if (WR_READY !== 1'b1 || PROG_LEN !== 5'd1) begin
            failures++;
            $display("FAIL bp_gap: ready=%b len=%0d, want 1/1", WR_READY, PROG_LEN);
        end
        WR_VALID = 1'b1; WR_DATA = 8'hA2; WR_LAST = 1'b1;
        tick();
        idle();
        checks++;
        if (WR_READY !== 1'b0 || PROG_LEN !== 5'd2) begin
            failures++;
            $display("FAIL bp_end: ready=%b len=%0d, want 0/2", WR_READY, PROG_LEN);
        end
        w_buf[0] = 8'hA1; w_buf[1] = 8'hA2;
        set_exp(2);
        PC = 4'h0;
        tick();
        for (int p = 0; p < 16; p++) read_pc(p);
    endtask

    task automatic test_reload();
        reload_run(1'b0);
        w_buf[0] = 8'hF7;
        load_prog(1, 1'b1, 0, 1'b0);
        read_pc(1);
        read_pc(0);
        read_pc(2);
    endtask

    task automatic test_reset_mid_load();
        reload_run(1'b0);
        for (int i = 0; i < 5; i++) begin
            WR_VALID = 1'b1; WR_DATA = 8'($urandom) | 8'h01; WR_LAST = 1'b0;
            tick();
        end
        idle();
        RST = 1'b1;
        tick();
        checks++;
        if (PROG_LEN !== 5'd0 || WR_READY !== 1'b0 || CPU_RST !== 1'b1 || LOADED !== 1'b0 || ORDER !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset: len=%0d ready=%b cpu_rst=%b loaded=%b order=%h, want 0/0/1/0/00",
                     PROG_LEN, WR_READY, CPU_RST, LOADED, ORDER);
        end
        RST = 1'b0;
        wait_clear(1'b0);
        w_buf[0] = 8'h5C;
        load_prog(1, 1'b1, 0, 1'b0);
        for (int p = 0; p < 6; p++) read_pc(p);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            bit lf;
            reload_run(1'b1);
            n  = int'($urandom_range(1, 16));
            lf = (n < 16) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < 16; i++) w_buf[i] = 8'($urandom);
            load_prog(n, lf, 30, 1'b1);
            for (int k = 0; k < 12; k++) read_pc(int'($urandom_range(15)));
        end
    endtask

    initial begin
        RST = 1'b1;
        PC  = 4'h0;
        idle();
        test_reset();
        test_short_load();
        test_full_load();
        test_reload();
        test_backpressure();
        test_reset_mid_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prog_fetch_unit

`default_nettype wire
